// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered read data, status flags,
// per-request ack/error pulses and a last-operation code.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [2:0]            state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_TH);

  localparam logic [2:0] ST_INIT     = 3'b000;
  localparam logic [2:0] ST_NO_OP    = 3'b001;
  localparam logic [2:0] ST_WRITE    = 3'b010;
  localparam logic [2:0] ST_WR_ERROR = 3'b011;
  localparam logic [2:0] ST_READ     = 3'b100;
  localparam logic [2:0] ST_RD_ERROR = 3'b101;
  localparam logic [2:0] ST_RD_WR    = 3'b110;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [2:0]            state_d;

  assign data_count   = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= AFULL_CNT);
  assign almost_empty = (count_q <= AEMPTY_CNT);

  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_en);

  // A rejected read outranks the write outcome; with rd_en high a write is
  // always accepted, so WR_ERROR only arises without a read request.
  always_comb begin
    state_d = ST_NO_OP;
    if (rd_ok && wr_ok)
      state_d = ST_RD_WR;
    else if (rd_en && !rd_ok)
      state_d = ST_RD_ERROR;
    else if (wr_en && !wr_ok)
      state_d = ST_WR_ERROR;
    else if (rd_ok)
      state_d = ST_READ;
    else if (wr_ok)
      state_d = ST_WRITE;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[tail] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      dout    <= '0;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
      state   <= ST_INIT;
    end else begin
      if (wr_ok)
        tail <= tail + 1'b1;
      if (rd_ok) begin
        dout <= mem[head];
        head <= head + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      wr_ack <= wr_ok;
      wr_err <= wr_en & ~wr_ok;
      rd_ack <= rd_ok;
      rd_err <= rd_en & ~rd_ok;
      state  <= state_d;
    end
  end

endmodule
